rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 136 +++++++++++++
 tb/tb_rom_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter that gives NUM_REQ requesters shared access to a
// single ROM. The ROM has a one-cycle registered read latency. A read runs
// IDLE -> ISSUE -> CAPTURE, and at most one read is in flight at a time.
module rom_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  output logic                          rom_enable,
  input  logic [DATA_WIDTH-1:0]         rom_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;       // round-robin priority pointer
  logic [PTR_W-1:0]        owner_q, owner_d;   // requester of the read in flight
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic                    rom_enable_q, rom_enable_d;
  logic [PTR_W-1:0]        win_idx;
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];

  // Search starts at p and wraps. The pointer is always below NUM_REQ, so
  // the index used on r stays in range for any NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [PTR_W-1:0]   p);
    logic [PTR_W-1:0] c;
    logic             found;
    rr_pick = p;
    found   = 1'b0;
    c       = p;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && r[c]) begin
        found   = 1'b1;
        rr_pick = c;
      end
      c = (c == LAST_IDX) ? '0 : c + 1'b1;
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Split the packed address bus into one slice per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign win_idx = rr_pick(req, ptr_q);

  // Next-state logic and next values of all registered outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. Without a
    // default, a path that leaves a signal unassigned would infer a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rom_addr_d   = rom_addr_q;
    rom_enable_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d      = ISSUE;
          owner_d      = win_idx;
          gnt_d        = onehot(win_idx);
          rom_enable_d = 1'b1;
          rom_addr_d   = addr_arr[win_idx];
          ptr_d        = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // rom_data is valid only in this cycle, so this is the only place it is sampled.
        state_d     = IDLE;
        rsp_data_d  = rom_data;
        rsp_valid_d = onehot(owner_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together at the edge, whatever the statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rom_addr_q   <= '0;
      rom_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rom_addr_q   <= rom_addr_d;
      rom_enable_q <= rom_enable_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rom_addr   = rom_addr_q;
  assign rom_enable = rom_enable_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter. The driver issues directed and random requests and
// runs a transaction-level reference model. The model pushes the expected
// grant and response events into queues. A separate monitor compares the DUT
// against those queues every cycle.
module tb_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            busy;
  logic [AW-1:0]   rom_addr;
  logic            rom_enable;
  wire  [DW-1:0]   rom_data;

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .rom_addr(rom_addr), .rom_enable(rom_enable), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // ROM model: registered read, output high-Z when no read was issued.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rom_q;
  logic          rom_v;
  always @(posedge clk) begin
    rom_q <= mem[rom_addr];
    rom_v <= rom_enable;
  end
  assign rom_data = rom_v ? rom_q : 'z;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int            edge_no;
    int            who;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          gq[$];
  exp_t          rq[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            ptr      = 0;
  int            next_free = 0;
  int            last_arb = -100;
  logic [DW-1:0] exp_hold = '0;
  logic [AW-1:0] exp_addr = '0;

  logic          rst_v;
  logic [N-1:0]  req_v;
  logic [AW-1:0] addr_v [N];
  int            last_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Rotate the request vector so that position 0 is the priority holder,
  // take the lowest set bit, then map it back to a requester number.
  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [2*N-1:0] two;
    logic [N-1:0]   rot;
    two = {r, r};
    rot = two[p +: N];
    for (int k = 0; k < N; k++)
      if (rot[k]) return (p + k) % N;
    return -1;
  endfunction

  // Drive one cycle and advance the model for the coming edge.
  // mode 0: the winner drops req. mode 1: all requests are held.
  // mode 2: the winner either drops or re-requests with a new address.
  task automatic step(input int mode);
    int e;
    e      = edge_cnt + 1;
    last_w = -1;
    rst_n  = rst_v;
    req    = req_v;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_v[i];
    if (!rst_v) begin
      gq.delete();
      rq.delete();
      ptr       = 0;
      next_free = e + 1;
      last_arb  = -100;
      exp_hold  = '0;
      exp_addr  = '0;
    end else if (e >= next_free && req_v != '0) begin
      last_w = pick(req_v, ptr);
      gq.push_back('{edge_no: e,     who: last_w, data: '0});
      rq.push_back('{edge_no: e + 2, who: last_w, data: mem[addr_v[last_w]]});
      ptr       = (last_w + 1) % N;
      next_free = e + 3;
      last_arb  = e;
      exp_addr  = addr_v[last_w];
    end
    if (last_w >= 0) begin
      if (mode == 0) req_v[last_w] = 1'b0;
      else if (mode == 2) begin
        if ($urandom_range(1, 0) == 1) addr_v[last_w] = AW'($urandom_range(255, 0));
        else req_v[last_w] = 1'b0;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) step(mode);
  endtask

  // Monitor: on each falling edge, pop any expected event and compare.
  initial begin
    logic [N-1:0] eg, ev;
    logic         ee, eb;
    forever begin
      @(negedge clk);
      eg = '0;
      ee = 1'b0;
      ev = '0;
      if (gq.size() != 0 && gq[0].edge_no == edge_cnt) begin
        eg = N'(1) << gq[0].who;
        ee = 1'b1;
        void'(gq.pop_front());
      end
      if (rq.size() != 0 && rq[0].edge_no == edge_cnt) begin
        ev       = N'(1) << rq[0].who;
        exp_hold = rq[0].data;
        void'(rq.pop_front());
      end
      eb = (edge_cnt - last_arb == 0) || (edge_cnt - last_arb == 1);
      check("gnt",            gnt,                  eg);
      check("rom_enable",     rom_enable,           ee);
      check("rsp_valid",      rsp_valid,            ev);
      check("rsp_data",       rsp_data,             exp_hold);
      check("rom_addr",       rom_addr,             exp_addr);
      check("busy",           busy,                 eb);
      check("gnt_onehot0",    $onehot0(gnt),        1);
      check("rsp_onehot0",    $onehot0(rsp_valid),  1);
      check("rsp_data_known", $isunknown(rsp_data), 0);
    end
  end

  // Stimulus: directed scenarios first, then random traffic.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h12345678;
    mem[2] = 32'hABCDEF01;
    rst_v = 1'b0;
    req_v = '0;
    for (int i = 0; i < N; i++) addr_v[i] = '0;

    // Reset, then a single read by requester 0 at address 0.
    run(2, 0);
    rst_v = 1'b1;
    run(1, 0);
    req_v = 4'b0001;
    run(5, 0);

    // All four requesters held high with addresses 0,1,2,0: five grants.
    rst_v = 1'b0;
    run(1, 0);
    rst_v = 1'b1;
    addr_v[0] = 8'd0;
    addr_v[1] = 8'd1;
    addr_v[2] = 8'd2;
    addr_v[3] = 8'd0;
    req_v = 4'b1111;
    run(15, 1);
    req_v = '0;
    run(3, 0);

    // Pointer wrap: grant requester 3, then 1001 must go to requester 0.
    rst_v = 1'b0;
    run(1, 0);
    rst_v = 1'b1;
    req_v = 4'b1000;
    run(3, 0);
    req_v = 4'b1001;
    run(6, 0);

    // Reset in the CAPTURE cycle aborts the read; afterwards 0110 grants requester 1.
    addr_v[1] = 8'd2;
    req_v = 4'b0010;
    run(2, 0);
    rst_v = 1'b0;
    run(1, 0);
    rst_v = 1'b1;
    req_v = 4'b0110;
    run(6, 0);

    // Address of requester 2 changes during ISSUE; response uses the old address.
    req_v = 4'b0000;
    run(3, 0);
    addr_v[2] = 8'd1;
    req_v = 4'b0100;
    run(1, 0);
    addr_v[2] = 8'd2;
    run(4, 0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 900; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_v[i] && $urandom_range(3, 0) == 0) begin
          req_v[i]  = 1'b1;
          addr_v[i] = AW'($urandom_range(255, 0));
        end
        else if (!req_v[i]) addr_v[i] = AW'($urandom_range(255, 0));
      rst_v = ($urandom_range(99, 0) != 0);
      step(2);
    end
    rst_v = 1'b1;
    req_v = '0;
    run(6, 0);

    check("queues_drained", 64'(gq.size() + rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
